mem_rd_streamer: RTL and testbench
==================================

# mem_rd_streamer

Read-stream engine sitting directly upstream of the fixed-latency memory delay line in the accelerator datapath. On a start command it issues a contiguous run of word reads (base address, length) to the SRAM port, whose read data returns through the `RD_LAT`-deep delay line. It then captures the returning words in a credit-protected FIFO and presents them downstream on a valid/ready stream. Credit accounting guarantees that no returning word is ever dropped, whatever the downstream backpressure.

## Interface
- `ADDR_W`, 16, word-address width
- `DATA_W`, 32, data width (matches 32-bit delay line)
- `LEN_W`, 16, transfer-length width (words)
- `RD_LAT`, 8, cycles from `mem_re` to valid `mem_rdata`; legal range 1..64
- `FIFO_DEPTH`, 16, capture FIFO entries; must be power of 2 and ≥ `RD_LAT`+2
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command pulse; sampled only in IDLE
- `base_addr`  in  ADDR_W  first word address, sampled with `start`
- `len`  in  LEN_W  word count, sampled with `start`
- `busy`  out  1  high from cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the last word is accepted downstream
- `mem_re`  out  1  read strobe to SRAM
- `mem_addr`  out  ADDR_W  read address, valid with `mem_re`
- `mem_rdata`  in  DATA_W  read data, valid exactly `RD_LAT` cycles after `mem_re`
- `m_valid`  out  1  output word valid
- `m_data`  out  DATA_W  output word
- `m_ready`  in  1  downstream accept

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE→ISSUE on `start` with `len`≠0.
  - IDLE→DRAIN on `start` with `len`=0; no reads are issued and `done` fires the next cycle.
  - ISSUE→DRAIN after the last read is issued.
  - DRAIN→IDLE when in-flight count = 0, FIFO is empty, and the output register is empty; `done` pulses in that cycle.
- `start` is ignored while `busy`.
- Issue rule: `mem_re`=1 in ISSUE only when `fifo_count + out_reg_full + inflight < FIFO_DEPTH + 1`.
  - The count includes the output register.
  - This guarantees a slot for every returning word.
- `mem_addr` starts at `base_addr` and increments by 1 per issued read. It wraps modulo 2^`ADDR_W` with no error.
- In-flight tracking: an `RD_LAT`-bit valid pipeline mirrors `mem_re`.
  - The pipeline output is the capture strobe for `mem_rdata`.
  - `inflight` is the popcount, maintained as an up/down counter of width clog2(`RD_LAT`+1).
- Data order is preserved: output words appear in address order.
- FIFO overflow is impossible by construction; any write to a full FIFO is a design error (assertion).
- Output stage: a registered `m_valid`/`m_data`, refilled from the FIFO.
  - While `m_valid`=1 and `m_ready`=0, `m_data` holds stable.
  - Once asserted, `m_valid` stays high until the handshake completes.
- Reset (including mid-transfer) does all of the following:
  - returns the FSM to IDLE;
  - clears the valid pipeline, FIFO pointers, and counters;
  - discards words still returning from memory, which are never captured.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_re`=0, `mem_addr`=0, `m_valid`=0, `m_data`=0.
- Accepted `start` at cycle T:
  - `busy`=1 at T+1;
  - first `mem_re` at T+1.
- Read issued at cycle k: data captured at k+`RD_LAT` and presented with `m_valid` no earlier than k+`RD_LAT`+1.
- First-word latency from `start` is `RD_LAT`+2 cycles.
- Sustained throughput is 1 word/cycle while `m_ready`=1.
- `done` asserts in the cycle after the final output handshake; `busy` falls in the same cycle as `done`.
- A new `start` is accepted in the cycle after `done`.
- Simultaneous FIFO write and read in one cycle leaves the count unchanged; this is legal when full or empty.

## Test plan
- Reset, then `start` base=0x0010, len=4, `m_ready`=1 → `mem_re` on 4 consecutive cycles, addresses 0x10–0x13, 4 output words in order at T+10..T+13 (`RD_LAT`=8), `done` at T+14.
- len=64, `m_ready`=0 for 100 cycles then 1 → at most `FIFO_DEPTH`+1=17 reads issued before stall; all 64 words delivered in order; no overflow assertion fires.
- base=0xFFFE, len=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- len=0 → no `mem_re`, `done` one cycle after `start`; `start` pulses while `busy` produce no extra reads.
- `rst` asserted mid-transfer with 5 reads in flight → all outputs return to reset values the next cycle; stale `mem_rdata` is never presented; a following len=2 transfer delivers exactly 2 correct words.
- Random `m_ready` toggling, len=200 → scoreboard matches memory model; `m_data` is stable whenever `m_valid`=1 and `m_ready`=0.

Source files
------------

// File: rtl/mem_rd_streamer_if.sv
// Command, SRAM read port and output stream of the read-stream engine.
// master = the engine, slave = its environment.
interface mem_rd_streamer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  start, base_addr, len, mem_rdata, m_ready,
        output busy, done, mem_re, mem_addr, m_valid, m_data
    );

    modport slave (
        output start, base_addr, len, mem_rdata, m_ready,
        input  busy, done, mem_re, mem_addr, m_valid, m_data
    );
endinterface

// File: rtl/mem_rd_streamer.sv
// Issues a contiguous run of SRAM reads and streams the returning words
// out through a credit-protected capture FIFO and a registered output.
module mem_rd_streamer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int RD_LAT     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic              clk,
    input logic              rst,
    mem_rd_streamer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 3);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    logic              busy_q;
    logic              done_q;
    logic              re_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] nxt_q;
    logic [LEN_W-1:0]  rem_q;

    logic [RD_LAT-1:0] vp;
    logic [IW-1:0]     inflight;

    logic [DATA_W-1:0] fifo [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    logic              ov_q;
    logic [DATA_W-1:0] od_q;

    logic cap;
    logic take;
    logic f_empty;
    logic push;
    logic pop;
    logic credit_ok;
    logic drain_done;

    assign cap = vp[RD_LAT-1];

    always_comb begin
        take    = !ov_q || bus.m_ready;
        f_empty = (cnt == '0);
        pop     = take && !f_empty;
        push    = cap && !(take && f_empty);
        // The read on the port this cycle already owns a slot.
        credit_ok = (SW'(cnt) + SW'(ov_q) + SW'(inflight) + SW'(re_q))
                    < SW'(FIFO_DEPTH + 1);
        drain_done = (inflight == '0) && f_empty && take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            re_q   <= 1'b0;
            addr_q <= '0;
            nxt_q  <= '0;
            rem_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state  <= ISSUE;
                            busy_q <= 1'b1;
                            re_q   <= 1'b1;
                            addr_q <= bus.base_addr;
                            nxt_q  <= bus.base_addr + 1'b1;
                            rem_q  <= bus.len - 1'b1;
                        end else begin
                            state  <= DRAIN;
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (rem_q == '0) begin
                        state <= DRAIN;
                        re_q  <= 1'b0;
                    end else if (credit_ok) begin
                        re_q   <= 1'b1;
                        addr_q <= nxt_q;
                        nxt_q  <= nxt_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                    end else begin
                        re_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    // done is raised one edge early so it lines up with
                    // the first cycle in which everything is empty.
                    if (done_q) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end else if (drain_done) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vp       <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            ov_q     <= 1'b0;
            od_q     <= '0;
        end else begin
            vp       <= (vp << 1) | RD_LAT'(re_q);
            inflight <= inflight + IW'(re_q) - IW'(cap);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            if (take) begin
                if (!f_empty) begin
                    ov_q <= 1'b1;
                    od_q <= fifo[rd_ptr];
                end else if (cap) begin
                    ov_q <= 1'b1;
                    od_q <= bus.mem_rdata;
                end else begin
                    ov_q <= 1'b0;
                end
            end
            assert (!(push && !pop && cnt == CW'(FIFO_DEPTH)))
            else $error("mem_rd_streamer: capture fifo overflow");
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.mem_rdata;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_re   = re_q;
    assign bus.mem_addr = addr_q;
    assign bus.m_valid  = ov_q;
    assign bus.m_data   = od_q;
endmodule

// File: tb/tb_mem_rd_streamer.sv
// Directed and random transfers against an SRAM model with RD_LAT delay
// and a queue-based reference of the expected address/data streams.
module tb_mem_rd_streamer;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 16;
    localparam int RD_LAT     = 8;
    localparam int FIFO_DEPTH = 16;

    logic clk;
    logic rst;

    mem_rd_streamer_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) ifc ();

    mem_rd_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_re = 0;
    int n_hs = 0;
    int snap_re;
    int snap_hs;

    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];
    logic [DATA_W-1:0] mem_img [65536];

    bit                pv [RD_LAT+1];
    logic [ADDR_W-1:0] pa [RD_LAT+1];
    bit                hold_prev = 0;
    logic [DATA_W-1:0] hold_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SRAM with RD_LAT latency; between returns the bus carries junk.
    always @(negedge clk) begin
        for (int i = RD_LAT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = ifc.mem_re;
        pa[0] = ifc.mem_addr;
        ifc.mem_rdata = pv[RD_LAT] ? mem_img[pa[RD_LAT]] : $urandom();
    end

    always @(negedge clk) begin
        if (ifc.mem_re) begin
            n_re++;
            chk("read_expected", 64'(exp_addr.size() != 0), 64'd1);
            if (exp_addr.size() != 0)
                chk("mem_addr", ifc.mem_addr, exp_addr.pop_front());
        end
        if (ifc.m_valid && ifc.m_ready) begin
            n_hs++;
            chk("word_expected", 64'(exp_data.size() != 0), 64'd1);
            if (exp_data.size() != 0)
                chk("m_data", ifc.m_data, exp_data.pop_front());
        end
        if (hold_prev && !rst) begin
            chk("hold_valid", ifc.m_valid, 1);
            chk("hold_data", ifc.m_data, hold_d);
        end
        hold_prev = ifc.m_valid && !ifc.m_ready && !rst;
        hold_d = ifc.m_data;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, ifc.busy, 0);
        chk({tag, "_done"}, ifc.done, 0);
        chk({tag, "_mem_re"}, ifc.mem_re, 0);
        chk({tag, "_mem_addr"}, ifc.mem_addr, 0);
        chk({tag, "_m_valid"}, ifc.m_valid, 0);
        chk({tag, "_m_data"}, ifc.m_data, 0);
    endtask

    // Queues the expected stream, pulses start, returns at negedge of T+1.
    task automatic go(input logic [ADDR_W-1:0] base,
                      input logic [LEN_W-1:0] n);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = base + ADDR_W'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem_img[a]);
        end
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        ifc.base_addr = base;
        ifc.len = n;
        snap_re = n_re;
        snap_hs = n_hs;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        @(negedge clk);
        chk("busy_t1", ifc.busy, 64'(n != 0));
        chk("mem_re_t1", ifc.mem_re, 64'(n != 0));
    endtask

    task automatic wait_done(input int max, input bit rnd);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rnd) ifc.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ifc.done) seen = 1;
        end
        chk("done_seen", 64'(seen), 1);
        @(posedge clk);
        #1;
        ifc.m_ready = 1'b1;
    endtask

    task automatic check_xfer(input string tag, input int n);
        chk({tag, "_reads"}, 64'(n_re - snap_re), 64'(n));
        chk({tag, "_words"}, 64'(n_hs - snap_hs), 64'(n));
        chk({tag, "_addr_q"}, 64'(exp_addr.size()), 0);
        chk({tag, "_data_q"}, 64'(exp_data.size()), 0);
    endtask

    initial begin
        logic [LEN_W-1:0] rl;
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.base_addr = '0;
        ifc.len = '0;
        ifc.m_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem_img[i] = $urandom();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.m_ready = 1'b1;

        // Exact timing of a short transfer.
        go(16'h0010, 16'd4);
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            chk($sformatf("t_mem_re_%0d", i), ifc.mem_re, 64'(i <= 4));
            chk($sformatf("t_m_valid_%0d", i), ifc.m_valid,
                64'(i >= 10 && i <= 13));
            chk($sformatf("t_done_%0d", i), ifc.done, 64'(i == 14));
            chk($sformatf("t_busy_%0d", i), ifc.busy, 64'(i <= 13));
        end
        check_xfer("short", 4);

        // Long stall: only the credited slots may be requested.
        @(posedge clk);
        #1;
        ifc.m_ready = 1'b0;
        go(16'h0100, 16'd64);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("stall_reads", 64'(n_re - snap_re), 64'(FIFO_DEPTH + 1));
        chk("stall_valid", ifc.m_valid, 1);
        @(posedge clk);
        #1;
        ifc.m_ready = 1'b1;
        wait_done(300, 0);
        check_xfer("stall", 64);

        go(16'hFFFE, 16'd4);
        wait_done(50, 0);
        check_xfer("wrap", 4);

        go(16'h0055, 16'd0);
        chk("len0_done", ifc.done, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("len0_no_re", ifc.mem_re, 0);
            chk("len0_done_pulse", ifc.done, 0);
        end
        check_xfer("len0", 0);

        go(16'h0200, 16'd6);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            ifc.start = 1'b1;
            ifc.base_addr = 16'h0300;
            ifc.len = 16'd9;
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
        end
        wait_done(60, 0);
        check_xfer("busy_start", 6);

        // Reset with five reads outstanding.
        @(posedge clk);
        #1;
        ifc.m_ready = 1'b0;
        go(16'h0400, 16'd20);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        chk("rst_mid_reads", 64'(n_re - snap_re), 5);
        check_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_stale", ifc.m_valid, 0);
        end
        go(16'h0500, 16'd2);
        wait_done(40, 0);
        check_xfer("post_rst", 2);

        go(16'($urandom()), 16'd200);
        wait_done(3000, 1);
        check_xfer("rand200", 200);

        for (int k = 0; k < 3; k++) begin
            rl = 16'($urandom_range(1, 40));
            go(16'($urandom()), rl);
            wait_done(1000, 1);
            check_xfer("rand_short", int'(rl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
